// File: rtl/pattern_merge_pipe.sv
// pattern_merge_pipe: merges two channels, then runs them through STAGES elastic nand/nor pattern cells.
// Optional PATTERN_PARITY_EN adds carried parity, out_parity and a sticky parity_err flag.
module pattern_merge_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int MODE   = 0,
    parameter int CNT_W  = 16
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
`ifdef PATTERN_PARITY_EN
    output logic             out_parity,
    output logic             parity_err,
`endif
    output logic [CNT_W-1:0] xfer_count
);

    function automatic logic [WIDTH-1:0] pat(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] y;
        for (int i = 0; i < WIDTH; i++)
            y[i] = (i % 2 == 0) ? ~(a[i] & a[(i + 1) % WIDTH]) : ~(a[i] | a[(i + 1) % WIDTH]);
        return y;
    endfunction

    logic [STAGES-1:0][WIDTH-1:0] r_data;
    logic [STAGES-1:0]            r_valid;
    logic [CNT_W-1:0]             r_cnt;
    logic [STAGES-1:0][WIDTH-1:0] w_din;
    logic [STAGES-1:0]            w_vin;
    logic [STAGES-1:0]            w_rdy;
    logic [WIDTH-1:0]             w_m;
    logic                         w_fire;

    assign w_m = (MODE == 0) ? in_a ^ in_b : in_a;

    // A stage can advance if it or any stage downstream of it has a bubble.
    for (genvar k = 0; k < STAGES; k++) begin : g_rdy
        assign w_rdy[k] = out_ready | ~(&r_valid[STAGES-1:k]);
    end

    always_comb begin
        w_din[0] = pat(w_m);
        w_vin[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_din[k] = pat(r_data[k-1]);
            w_vin[k] = r_valid[k-1];
        end
    end

    assign in_ready   = w_rdy[0] & ~flush;
    assign out_data   = r_data[STAGES-1];
    assign out_valid  = r_valid[STAGES-1] & ~flush;
    assign w_fire     = out_valid & out_ready;
    assign xfer_count = r_cnt;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_data  <= '0;
            r_valid <= '0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_valid[k] <= w_vin[k];
                    if (w_vin[k]) r_data[k] <= w_din[k];
                end
            end
            if (w_fire) r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef PATTERN_PARITY_EN
    logic [STAGES-1:0] r_par;
    logic              r_perr;

    assign out_parity = out_valid & (^out_data);
    assign parity_err = r_perr;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_par  <= '0;
            r_perr <= 1'b0;
        end else begin
            if (!flush) begin
                for (int k = 0; k < STAGES; k++)
                    if (w_rdy[k] && w_vin[k]) r_par[k] <= ^w_din[k];
            end
            if (w_fire && (r_par[STAGES-1] != ^out_data)) r_perr <= 1'b1;
        end
    end
`endif

endmodule
